// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Optional AES_KEY_REUSE_EN keeps the last loaded key so later blocks can start on data_valid_in alone.
module aes128_encrypt_core #(
    parameter int KEY_LEN       = 128,
    parameter int DATA_LEN      = 128,
    parameter int NUMS_OF_ROUND = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_valid_in,
    input  logic [DATA_LEN-1:0] plain_text,
    input  logic                key_valid_in,
    input  logic [KEY_LEN-1:0]  cipher_key,
    output logic                data_valid_out,
    output logic [DATA_LEN-1:0] cipher_text
);
    // state | meaning
    // IDLE  | waiting for a start condition
    // BUSY  | rounds 1..NUMS_OF_ROUND in progress, inputs ignored
    typedef enum logic {IDLE, BUSY} fsm_e;

    localparam logic [3:0] LAST_ROUND = 4'(NUMS_OF_ROUND);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 via an addition chain, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i sits at row i%4, column i/4; ShiftRows pulls row r from column (c+r)%4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [7:0]   b [16];
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = b[4*((c+r)%4)+r];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    fsm_e                fsm_q, fsm_d;
    logic [3:0]          round_q, round_d;
    logic [DATA_LEN-1:0] state_q, state_d;
    logic [KEY_LEN-1:0]  key_q, key_d;
    logic [DATA_LEN-1:0] cipher_text_q, cipher_text_d;
    logic                data_valid_out_q, data_valid_out_d;

    logic                start;
    logic [KEY_LEN-1:0]  start_key;
    logic                last_round;
    logic [KEY_LEN-1:0]  next_key;
    logic [DATA_LEN-1:0] shifted;
    logic [DATA_LEN-1:0] round_out;

`ifdef AES_KEY_REUSE_EN
    logic                key_loaded_q, key_loaded_d;
    logic [KEY_LEN-1:0]  stored_key_q, stored_key_d;

    assign start     = data_valid_in && (key_valid_in || key_loaded_q);
    assign start_key = key_valid_in ? cipher_key : stored_key_q;
`else
    assign start     = data_valid_in && key_valid_in;
    assign start_key = cipher_key;
`endif

    assign last_round = (fsm_q == BUSY) && (round_q == LAST_ROUND);
    assign next_key   = key_expand(key_q, rcon(round_q));
    assign shifted    = sub_shift(state_q);
    assign round_out  = ((round_q == LAST_ROUND) ? shifted : mix_columns(shifted)) ^ next_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q            <= IDLE;
            round_q          <= '0;
            state_q          <= '0;
            key_q            <= '0;
            cipher_text_q    <= '0;
            data_valid_out_q <= 1'b0;
`ifdef AES_KEY_REUSE_EN
            key_loaded_q     <= 1'b0;
            stored_key_q     <= '0;
`endif
        end else begin
            fsm_q            <= fsm_d;
            round_q          <= round_d;
            state_q          <= state_d;
            key_q            <= key_d;
            cipher_text_q    <= cipher_text_d;
            data_valid_out_q <= data_valid_out_d;
`ifdef AES_KEY_REUSE_EN
            key_loaded_q     <= key_loaded_d;
            stored_key_q     <= stored_key_d;
`endif
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start) fsm_d = BUSY;
            BUSY:    if (last_round) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        round_d          = round_q;
        state_d          = state_q;
        key_d            = key_q;
        cipher_text_d    = cipher_text_q;
        data_valid_out_d = 1'b0;
        if (fsm_q == IDLE && start) begin
            state_d = plain_text ^ start_key;
            key_d   = start_key;
            round_d = 4'd1;
        end else if (fsm_q == BUSY) begin
            state_d = round_out;
            key_d   = next_key;
            round_d = round_q + 4'd1;
            if (last_round) begin
                cipher_text_d    = round_out;
                data_valid_out_d = 1'b1;
                round_d          = 4'd0;
            end
        end
`ifdef AES_KEY_REUSE_EN
        key_loaded_d = key_loaded_q;
        stored_key_d = stored_key_q;
        if (fsm_q == IDLE && key_valid_in) begin
            key_loaded_d = 1'b1;
            stored_key_d = cipher_key;
        end
`endif
    end

    assign data_valid_out = data_valid_out_q;
    assign cipher_text    = cipher_text_q;
endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed bench for aes128_encrypt_core: known-answer vectors, back-to-back, abort, single-valid.
// Expected ciphertexts and result cycles go into a scoreboard queue; a monitor pops them on each pulse.
module tb_aes128_encrypt_core;
    logic         clk = 1'b0;
    logic         reset;
    logic         data_valid_in;
    logic [127:0] plain_text;
    logic         key_valid_in;
    logic [127:0] cipher_key;
    logic         data_valid_out;
    logic [127:0] cipher_text;

    typedef struct {
        logic [127:0] ct;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] KAT1_PT = 128'hf34481ec3cc627bacd5dc3fb08f273e6;
    localparam logic [127:0] KAT1_CT = 128'h0336763e966d92595a567cc9ce537f5e;
    localparam logic [127:0] KAT2_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT2_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT2_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] KR_PT   = 128'h9798c4640bad75c7c3227db910174e72;
    localparam logic [127:0] KR_CT   = 128'ha9a1631bf4996954ebc093957b234589;

    aes128_encrypt_core dut (
        .clk            (clk),
        .reset          (reset),
        .data_valid_in  (data_valid_in),
        .plain_text     (plain_text),
        .key_valid_in   (key_valid_in),
        .cipher_key     (cipher_key),
        .data_valid_out (data_valid_out),
        .cipher_text    (cipher_text)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                assert (data_valid_out === 1'b0) else begin
                    errors++;
                    $error("FAIL unexpected_pulse: observed %b expected 0 at cycle %0d", data_valid_out, cyc);
                end
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert (cipher_text === e.ct) else begin
                    errors++;
                    $error("FAIL ciphertext: observed %h expected %h", cipher_text, e.ct);
                end
                checks++;
                assert (cyc === e.due) else begin
                    errors++;
                    $error("FAIL latency: observed cycle %0d expected cycle %0d", cyc, e.due);
                end
            end
        end
    end

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge: accept happens on the next posedge, result 10 edges later.
    task automatic start_block(input logic [127:0] pt, input logic [127:0] key,
                               input logic [127:0] ct, input bit expect_out);
        exp_t e;
        plain_text    = pt;
        cipher_key    = key;
        data_valid_in = 1'b1;
        key_valid_in  = 1'b1;
        if (expect_out) begin
            e.ct  = ct;
            e.due = cyc + 11;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        data_valid_in = 1'b0;
        key_valid_in  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        reset         = 1'b1;
        data_valid_in = 1'b1;
        key_valid_in  = 1'b1;
        plain_text    = KAT1_PT;
        cipher_key    = '0;

        repeat (3) begin
            @(negedge clk);
            check128("reset_valid", {127'h0, data_valid_out}, 128'h0);
            check128("reset_ct", cipher_text, 128'h0);
        end
        reset         = 1'b0;
        data_valid_in = 1'b0;
        key_valid_in  = 1'b0;
        idle_cycles(12);

        start_block(KAT1_PT, 128'h0, KAT1_CT, 1'b1);
        idle_cycles(13);
        check128("ct_hold", cipher_text, KAT1_CT);

        start_block(KAT2_PT, KAT2_K, KAT2_CT, 1'b1);
        idle_cycles(12);

        // Held valids; junk on the inputs except at the cycles the core is idle.
        for (int i = 0; i < 40; i++) begin
            data_valid_in = 1'b1;
            key_valid_in  = 1'b1;
            if (i % 11 == 0) begin
                plain_text = '0;
                cipher_key = '0;
                e.ct  = ZERO_CT;
                e.due = cyc + 11;
                sb.push_back(e);
            end else begin
                plain_text = {$urandom, $urandom, $urandom, $urandom};
                cipher_key = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk);
            @(negedge clk);
        end
        data_valid_in = 1'b0;
        key_valid_in  = 1'b0;
        idle_cycles(12);

        start_block(KAT1_PT, 128'h0, KAT1_CT, 1'b0);
        idle_cycles(4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check128("abort_valid", {127'h0, data_valid_out}, 128'h0);
        check128("abort_ct", cipher_text, 128'h0);
        idle_cycles(14);
        check128("abort_ct_after", cipher_text, 128'h0);

        start_block(KAT1_PT, 128'h0, KAT1_CT, 1'b1);
        idle_cycles(12);

        cipher_key   = '0;
        key_valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_valid_in = 1'b0;
        cipher_key   = {$urandom, $urandom, $urandom, $urandom};
        idle_cycles(12);

        plain_text    = KR_PT;
        data_valid_in = 1'b1;
`ifdef AES_KEY_REUSE_EN
        e.ct  = KR_CT;
        e.due = cyc + 11;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        data_valid_in = 1'b0;
        idle_cycles(12);
        check128("key_reuse_ct", cipher_text, KR_CT);
`else
        idle_cycles(14);
        data_valid_in = 1'b0;
        check128("single_valid_ct", cipher_text, KAT1_CT);
`endif

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL missing_pulses: observed %0d outstanding expected 0", sb.size());
        end
        idle_cycles(15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes128_encrypt_core.md
Name: aes128_encrypt_core

Overview:
- Iterative AES-128 encryption engine (FIPS-197), one round per clock, with on-the-fly round-key expansion.
- Accepts a 128-bit plaintext and a 128-bit cipher key, then returns a 128-bit ciphertext with a one-cycle valid pulse.
- Top-level crypto block; sits between a data/key source and a ciphertext consumer.
- Encrypt only. There is no decryption path.

Parameters:
- KEY_LEN, 128, key width in bits. Only 128 is supported.
- DATA_LEN, 128, block width in bits. Only 128 is supported.
- NUMS_OF_ROUND, 10, number of AES rounds. Only 10 is supported.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- data_valid_in  input  1  plain_text is valid.
- plain_text  input  DATA_LEN  plaintext block.
- key_valid_in  input  1  cipher_key is valid.
- cipher_key  input  KEY_LEN  AES-128 key.
- data_valid_out  output  1  one-cycle pulse; cipher_text holds a new result.
- cipher_text  output  DATA_LEN  ciphertext block, registered.

Behaviour:
- Byte order follows FIPS-197: bits [127:120] are byte 0, and the state is filled column-major. Same rule for key and ciphertext.
- Reset: while reset=1 at a clock edge, the FSM goes to IDLE, the round counter to 0, data_valid_out to 0 and cipher_text to 0. All internal state and key registers clear. A reset mid-operation aborts the block and produces no output pulse.
- FSM has two states, IDLE and BUSY.
- IDLE -> BUSY: on an edge (cycle T) where data_valid_in=1 and key_valid_in=1:
  - state <= plain_text XOR cipher_key (round 0 AddRoundKey);
  - round key register <= cipher_key;
  - round counter <= 1.
- BUSY: cycles T+1 to T+10 each perform one round; the counter runs 1 to 10.
  - Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
  - The next round key is computed combinationally from the current one: RotWord, SubWord, Rcon[round] with Rcon = 01,02,04,08,10,20,40,80,1b,36.
- Output: at edge T+10, cipher_text <= round-10 result and data_valid_out <= 1; the FSM returns to IDLE.
  - Latency is 10 cycles from the accepting edge to data_valid_out high.
  - data_valid_out is high for exactly one cycle.
  - cipher_text holds its value until the next result or reset.
- Inputs are ignored while BUSY. No queuing and no back-pressure signal.
- If both valids stay high, a new block is accepted on the edge after the result edge, i.e. every 11 cycles.
- If only one of data_valid_in / key_valid_in is high in IDLE, nothing starts (see Optional Feature).
- S-box: any combinational implementation (e.g. 256-entry case or GF(2^8) inverse plus affine transform). 20 instances: 16 for the state, 4 for key expansion.
- MixColumns uses xtime over GF(2^8) with polynomial 0x11b.

Optional Feature:
- Macro: AES_KEY_REUSE_EN.
- Defined:
  - Adds a key_loaded flag. It is set on any IDLE edge with key_valid_in=1, and cleared by reset.
  - That edge also latches cipher_key into a stored-key register.
  - A block starts in IDLE when data_valid_in=1 and either key_valid_in=1 (use cipher_key) or key_loaded=1 (use the stored key).
- Undefined: a start requires both valids in the same cycle, and no key is stored between blocks.

Test Plan:
- Reset check: hold reset=1 for 3 cycles with valids high -> data_valid_out=0, cipher_text=0, no start.
- KAT 1: key=0, pt=f34481ec3cc627bacd5dc3fb08f273e6, both valids pulsed one cycle -> exactly 10 cycles later a single data_valid_out pulse with ct=0336763e966d92595a567cc9ce537f5e.
- KAT 2 (FIPS-197): key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff -> ct=69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back: key=0, pt=0, valids held high for 40 cycles -> ct=66e94bd4ef8a2c3b884cfa59ca342b2e; pulses spaced 11 cycles apart; input changes while BUSY have no effect.
- Abort: start KAT 1, assert reset at round 5 -> no pulse, outputs 0. A new start after reset produces the correct result.
- Single-valid: data_valid_in=1 with key_valid_in=0 -> no output without the macro. With AES_KEY_REUSE_EN after an earlier key load of 0, pt=9798c4640bad75c7c3227db910174e72 -> ct=a9a1631bf4996954ebc093957b234589.
